// File: rtl/string_led_controller.sv
// Wishbone-mapped WS2812-style LED string driver: 64-word colour RAM serialised
// MSB-first with programmable bit timing and a trailing latch-low period.
module string_led_controller #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        led_o,
  output logic        led_oeb,
  output logic        irq_o
);
  localparam int MAX_LEDS = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    LATCH = 3'd4
  } state_t;

  state_t      state_r, state_nxt;
  logic        ack_r, start_req_r, done_r, irq_en_r, irq_r, led_r;
  logic        done_nxt, irq_en_nxt;
  logic [31:0] dat_r, rdata_s;
  logic [7:0]  num_r, t_period_r, t0h_r, t1h_r;
  logic [15:0] latch_r, cnt_r;
  logic [23:0] ram_r [0:MAX_LEDS-1];
  logic [23:0] shift_r;
  logic [5:0]  led_idx_r;
  logic [4:0]  bit_idx_r;

  logic        hit_s, acc_s, wr_s, wr_ctrl_s, busy_s;
  logic [6:0]  num_eff_s;
  logic [7:0]  p_eff_s, h_raw_s, h_min_s, h_eff_s, end_cnt_s;
  logic [15:0] latch_eff_s;
  logic        last_bit_s, last_led_s, load_next_s, bit_end_s, high_end_s, latch_done_s;
  state_t      end_tgt_s;
  logic        unused_s;

  assign hit_s     = (wbs_adr_i[31:9] == BASE_ADDR[31:9]);
  assign acc_s     = wbs_cyc_i & wbs_stb_i & ~ack_r & hit_s;
  assign wr_s      = acc_s & wbs_we_i;
  assign wr_ctrl_s = wr_s & ~wbs_adr_i[8] & (wbs_adr_i[7:2] == 6'd0) & wbs_sel_i[0];
  assign busy_s    = (state_r != IDLE);
  assign unused_s  = ^{wbs_sel_i[3], wbs_dat_i[31:24], wbs_adr_i[1:0]};

  // Timing clamps are applied live so mid-frame TIMING writes shape the following bits.
  assign num_eff_s   = (num_r > 8'(MAX_LEDS)) ? 7'(MAX_LEDS) : num_r[6:0];
  assign p_eff_s     = (t_period_r < 8'd2) ? 8'd2 : t_period_r;
  assign h_raw_s     = shift_r[23] ? t1h_r : t0h_r;
  assign h_min_s     = (h_raw_s == 8'd0) ? 8'd1 : h_raw_s;
  assign h_eff_s     = (h_min_s >= p_eff_s) ? (p_eff_s - 8'd1) : h_min_s;
  assign latch_eff_s = (latch_r == 16'd0) ? 16'd1 : latch_r;

  assign last_bit_s   = (bit_idx_r == 5'd0);
  assign last_led_s   = (({1'b0, led_idx_r} + 7'd1) >= num_eff_s);
  assign load_next_s  = last_bit_s & ~last_led_s;
  // The LOAD cycle of the next LED replaces the final cycle of this bit's low time.
  assign end_cnt_s    = load_next_s ? (p_eff_s - 8'd2) : (p_eff_s - 8'd1);
  assign bit_end_s    = (cnt_r >= {8'd0, end_cnt_s});
  assign high_end_s   = (cnt_r >= {8'd0, h_eff_s - 8'd1});
  assign latch_done_s = (state_r == LATCH) && (cnt_r >= (latch_eff_s - 16'd1));
  assign end_tgt_s    = load_next_s ? LOAD : (last_bit_s ? LATCH : HIGH);

  // Register read multiplexer
  always_comb begin
    rdata_s = 32'd0;
    if (wbs_adr_i[8]) begin
      rdata_s = {8'd0, ram_r[wbs_adr_i[7:2]]};
    end else begin
      case (wbs_adr_i[7:2])
        6'd0:    rdata_s = {29'd0, irq_en_r, done_r, busy_s};
        6'd1:    rdata_s = {24'd0, num_r};
        6'd2:    rdata_s = {8'd0, t1h_r, t0h_r, t_period_r};
        6'd3:    rdata_s = {16'd0, latch_r};
        default: rdata_s = 32'd0;
      endcase
    end
  end

  // Next values of DONE and IRQ_EN; frame completion wins over a same-cycle clear
  always_comb begin
    done_nxt   = done_r;
    irq_en_nxt = irq_en_r;
    if (wr_ctrl_s) begin
      irq_en_nxt = wbs_dat_i[2];
      done_nxt   = wbs_dat_i[1] ? 1'b0 : done_r;
    end else begin
      irq_en_nxt = irq_en_r;
    end
    if (start_req_r && (state_r == IDLE)) begin
      done_nxt = 1'b0;
    end else begin
      done_nxt = done_nxt;
    end
    if (latch_done_s) begin
      done_nxt = 1'b1;
    end else begin
      done_nxt = done_nxt;
    end
  end

  // Wishbone slave and control/status registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_r       <= 1'b0;
      dat_r       <= 32'd0;
      num_r       <= 8'd0;
      t_period_r  <= 8'd50;
      t0h_r       <= 8'd14;
      t1h_r       <= 8'd28;
      latch_r     <= 16'd2000;
      start_req_r <= 1'b0;
      done_r      <= 1'b0;
      irq_en_r    <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      ack_r       <= acc_s;
      dat_r       <= (acc_s & ~wbs_we_i) ? rdata_s : 32'd0;
      start_req_r <= wr_ctrl_s & wbs_dat_i[0] & ~busy_s;
      done_r      <= done_nxt;
      irq_en_r    <= irq_en_nxt;
      irq_r       <= done_nxt & irq_en_nxt;
      if (wr_s && !wbs_adr_i[8]) begin
        case (wbs_adr_i[7:2])
          6'd1: if (wbs_sel_i[0]) num_r <= wbs_dat_i[7:0];
          6'd2: begin
            if (wbs_sel_i[0]) t_period_r <= wbs_dat_i[7:0];
            if (wbs_sel_i[1]) t0h_r      <= wbs_dat_i[15:8];
            if (wbs_sel_i[2]) t1h_r      <= wbs_dat_i[23:16];
          end
          6'd3: begin
            if (wbs_sel_i[0]) latch_r[7:0]  <= wbs_dat_i[7:0];
            if (wbs_sel_i[1]) latch_r[15:8] <= wbs_dat_i[15:8];
          end
          default: ;
        endcase
      end
    end
  end

  // Colour RAM, byte-writable and deliberately not reset
  always_ff @(posedge wb_clk_i) begin
    if (wr_s && wbs_adr_i[8]) begin
      if (wbs_sel_i[0]) ram_r[wbs_adr_i[7:2]][7:0]   <= wbs_dat_i[7:0];
      if (wbs_sel_i[1]) ram_r[wbs_adr_i[7:2]][15:8]  <= wbs_dat_i[15:8];
      if (wbs_sel_i[2]) ram_r[wbs_adr_i[7:2]][23:16] <= wbs_dat_i[23:16];
    end
  end

  // Serialiser next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (start_req_r) state_nxt = (num_eff_s == 7'd0) ? LATCH : LOAD;
        else             state_nxt = IDLE;
      end
      LOAD: state_nxt = HIGH;
      HIGH: begin
        if (bit_end_s)       state_nxt = end_tgt_s;
        else if (high_end_s) state_nxt = LOW;
        else                 state_nxt = HIGH;
      end
      LOW: begin
        if (bit_end_s) state_nxt = end_tgt_s;
        else           state_nxt = LOW;
      end
      LATCH: begin
        if (latch_done_s) state_nxt = IDLE;
        else              state_nxt = LATCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Serialiser state, counters and shift register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r   <= IDLE;
      cnt_r     <= 16'd0;
      led_idx_r <= 6'd0;
      bit_idx_r <= 5'd0;
      shift_r   <= 24'd0;
      led_r     <= 1'b0;
    end else begin
      state_r <= state_nxt;
      led_r   <= (state_nxt == HIGH);
      case (state_r)
        IDLE: begin
          cnt_r     <= 16'd0;
          led_idx_r <= 6'd0;
        end
        LOAD: begin
          shift_r   <= ram_r[led_idx_r];
          bit_idx_r <= 5'd23;
          cnt_r     <= 16'd0;
        end
        HIGH, LOW: begin
          if (bit_end_s) begin
            cnt_r     <= 16'd0;
            shift_r   <= {shift_r[22:0], 1'b0};
            bit_idx_r <= bit_idx_r - 5'd1;
            if (load_next_s) led_idx_r <= led_idx_r + 6'd1;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        LATCH:   cnt_r <= cnt_r + 16'd1;
        default: cnt_r <= 16'd0;
      endcase
    end
  end

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_r;
  assign led_o     = led_r;
  assign led_oeb   = 1'b0;
  assign irq_o     = irq_r;

endmodule

// File: tb/tb_string_led_controller.sv
// Directed self-checking bench for string_led_controller: register map, byte
// selects, waveform timing, interrupt, START-while-busy and mid-frame reset.
module tb_string_led_controller;
  localparam logic [31:0] A_CTRL   = 32'h3000_0000;
  localparam logic [31:0] A_NUM    = 32'h3000_0004;
  localparam logic [31:0] A_TIMING = 32'h3000_0008;
  localparam logic [31:0] A_LATCH  = 32'h3000_000C;
  localparam logic [31:0] A_RAM    = 32'h3000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] adr = 32'd0, wdat = 32'd0;
  logic        ack, led, oeb, irq;
  logic [31:0] rdat;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc_cnt = 0;
  logic smp [0:5999];
  logic irs [0:5999];

  string_led_controller dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .led_o    (led),
    .led_oeb  (oeb),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] q);
    logic got;
    got = 1'b0;
    q = 32'd0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        q = rdat;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) check("wb_ack_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] q;
    wb_xfer(1'b1, a, d, s, q);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] q);
    wb_xfer(1'b0, a, 32'd0, 4'hF, q);
  endtask

  task automatic sample(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      smp[i] = led;
      irs[i] = irq;
    end
  endtask

  initial begin
    logic [31:0] q;
    int bad, hk, edges, misplaced, t0, t1;
    logic seen, pulses;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", {31'd0, led}, 32'd0);
    check("rst_oeb", {31'd0, oeb}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", rdat, 32'd0);
    rst = 1'b0;
    wb_read(A_CTRL, q);   check("rst_ctrl", q, 32'h0000_0000);
    wb_read(A_NUM, q);    check("rst_num", q, 32'h0000_0000);
    wb_read(A_TIMING, q); check("rst_timing", q, 32'h001C_0E32);
    wb_read(A_LATCH, q);  check("rst_latch", q, 32'd2000);
    wb_read(32'h3000_0010, q); check("unmapped_read", q, 32'd0);

    // RAM readback: top byte is not stored
    for (int i = 0; i < 64; i++) wb_write(A_RAM + 32'(4 * i), 32'hFFA5_A5A5, 4'hF);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      wb_read(A_RAM + 32'(4 * i), q);
      if (q !== 32'h00A5_A5A5) bad++;
    end
    check("ram_readback_errors", bad, 32'd0);
    wb_write(A_NUM, 32'h0000_005A, 4'hF);
    wb_read(A_NUM, q); check("num_readback", q, 32'h0000_005A);

    // Byte select
    wb_write(A_RAM + 32'd12, 32'h0000_0000, 4'hF);
    wb_write(A_RAM + 32'd12, 32'hFFFF_FFFF, 4'b0010);
    wb_read(A_RAM + 32'd12, q); check("byte_select", q, 32'h0000_FF00);

    // One LED, 0x800001, IRQ_EN set to time DONE
    wb_write(A_RAM, 32'h0080_0001, 4'hF);
    wb_write(A_NUM, 32'd1, 4'hF);
    wb_write(A_CTRL, 32'h0000_0005, 4'hF);
    sample(3210);
    check("one_led_load_cycle_low", {31'd0, smp[0]}, 32'd0);
    for (int k = 0; k < 24; k++) begin
      bad = 0;
      hk = (k == 0 || k == 23) ? 28 : 14;
      for (int j = 0; j < 50; j++) if (smp[1 + 50 * k + j] !== (j < hk)) bad++;
      check($sformatf("one_led_bit%0d", 23 - k), bad, 32'd0);
    end
    bad = 0;
    for (int i = 1201; i <= 3200; i++) if (smp[i] !== 1'b0) bad++;
    check("one_led_latch_low", bad, 32'd0);
    check("one_led_irq_before_done", {31'd0, irs[3200]}, 32'd0);
    check("one_led_irq_at_done", {31'd0, irs[3201]}, 32'd1);
    wb_read(A_CTRL, q); check("one_led_ctrl_done", q, 32'h0000_0006);

    // Three LEDs: 72 evenly spaced rising edges, then interrupt
    wb_write(A_RAM, 32'h00FF_FFFF, 4'hF);
    wb_write(A_RAM + 32'd4, 32'h0000_0000, 4'hF);
    wb_write(A_RAM + 32'd8, 32'h0012_3456, 4'hF);
    wb_write(A_NUM, 32'd3, 4'hF);
    wb_write(A_CTRL, 32'h0000_0005, 4'hF);
    sample(5610);
    edges = 0;
    misplaced = 0;
    for (int i = 1; i < 5610; i++) begin
      if (smp[i] && !smp[i-1]) begin
        edges++;
        if (((i - 1) % 50) != 0) misplaced++;
      end
    end
    check("three_led_edges", edges, 32'd72);
    check("three_led_edge_spacing", misplaced, 32'd0);
    check("three_led_irq_before_done", {31'd0, irs[5600]}, 32'd0);
    check("three_led_irq_at_done", {31'd0, irs[5601]}, 32'd1);
    wb_write(A_CTRL, 32'h0000_0002, 4'hF);
    @(posedge clk); #1;
    check("irq_cleared", {31'd0, irq}, 32'd0);
    wb_read(A_CTRL, q); check("done_cleared", q, 32'h0000_0000);

    // NUM_LEDS=0: latch only; a second START while busy is ignored
    wb_write(A_NUM, 32'd0, 4'hF);
    wb_write(A_CTRL, 32'h0000_0005, 4'hF);
    t0 = cyc_cnt;
    pulses = 1'b0;
    seen = 1'b0;
    t1 = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (led) pulses = 1'b1;
    end
    wb_read(A_CTRL, q); check("busy_during_latch", q, 32'h0000_0005);
    wb_write(A_CTRL, 32'h0000_0005, 4'hF);
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      if (led) pulses = 1'b1;
      if (irq) begin
        seen = 1'b1;
        t1 = cyc_cnt;
      end
    end
    check("zero_led_irq_seen", {31'd0, seen}, 32'd1);
    check("zero_led_frame_len", t1 - t0, 32'd2001);
    check("zero_led_no_pulses", {31'd0, pulses}, 32'd0);

    // Clamps: T_PERIOD=2, T1H>=period, T0H=0, LOAD straight after HIGH
    wb_write(A_TIMING, 32'h0005_0002, 4'hF);
    wb_write(A_LATCH, 32'd4, 4'hF);
    wb_write(A_RAM, 32'h00FF_FFFF, 4'hF);
    wb_write(A_RAM + 32'd4, 32'h0000_0000, 4'hF);
    wb_write(A_NUM, 32'd2, 4'hF);
    wb_write(A_CTRL, 32'h0000_0005, 4'hF);
    sample(110);
    bad = 0;
    for (int i = 1; i <= 96; i++) if (smp[i] !== ((i % 2) == 1)) bad++;
    check("clamp_pattern", bad, 32'd0);
    bad = 0;
    for (int i = 97; i < 110; i++) if (smp[i] !== 1'b0) bad++;
    check("clamp_latch_low", bad, 32'd0);
    check("clamp_irq_before_done", {31'd0, irs[100]}, 32'd0);
    check("clamp_irq_at_done", {31'd0, irs[101]}, 32'd1);

    // Custom timing, then reset mid-frame
    wb_write(A_TIMING, 32'h001E_0A28, 4'hF);
    wb_write(A_NUM, 32'd1, 4'hF);
    wb_write(A_CTRL, 32'h0000_0001, 4'hF);
    sample(45);
    bad = 0;
    for (int i = 1; i <= 41; i++) if (smp[i] !== (i <= 30 || i == 41)) bad++;
    check("custom_timing_bit", bad, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_led", {31'd0, led}, 32'd0);
    check("midrst_ack", {31'd0, ack}, 32'd0);
    check("midrst_dat", rdat, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    wb_read(A_CTRL, q);   check("midrst_ctrl", q, 32'h0000_0000);
    wb_read(A_TIMING, q); check("midrst_timing", q, 32'h001C_0E32);
    wb_read(A_LATCH, q);  check("midrst_latch", q, 32'd2000);
    wb_read(A_RAM, q);    check("midrst_ram_retained", q, 32'h00FF_FFFF);
    pulses = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (led) pulses = 1'b1;
    end
    check("midrst_led_quiet", {31'd0, pulses}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/string_led_controller.md
# string_led_controller

Wishbone-attached controller for a daisy-chained string of WS2812-style addressable RGB LEDs. It sits in the Caravel user project area and is mapped into the management SoC's Wishbone space. It holds up to 64 24-bit colour words in an internal register file and serialises them onto one single-wire output with programmable pulse timing, followed by a latch (reset) low period. Firmware loads colours, writes START, and polls DONE or takes an interrupt.

## Interface
- BASE_ADDR, 32'h3000_0000: Wishbone base address; the block responds when wbs_adr_i[31:9] == BASE_ADDR[31:9].
- MAX_LEDS, 64: LED RAM depth in words.
- wb_clk_i  in  1  the single clock (40 MHz nominal, 25 ns).
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- led_o  out  1  serial LED data.
- led_oeb  out  1  pad output-enable, active-low; constant 0.
- irq_o  out  1  interrupt, level: DONE & IRQ_EN.

## Operation
- Register map (offset from BASE_ADDR):
  - 0x000 CTRL: [0] START (write 1 starts; reads as BUSY); [1] DONE (sticky, write 1 clears); [2] IRQ_EN. Reset 0.
  - 0x004 NUM_LEDS: [7:0], reset 0; values above MAX_LEDS are clamped to MAX_LEDS.
  - 0x008 TIMING: [7:0] T_PERIOD, [15:8] T0H, [23:16] T1H; reset 50/14/28 (1.25 us, 0.35 us, 0.7 us).
  - 0x00C LATCH: [15:0] latch-low cycles, reset 2000 (50 us).
  - 0x100-0x1FC LED RAM: word n = LED n colour [23:0] in GRB order; [31:24] read 0. Not reset.
- Writes honour wbs_sel_i per byte. Unmapped reads return 0; unmapped writes are ignored.
- FSM states: IDLE, LOAD, HIGH, LOW, LATCH.
  - IDLE: led_o = 0. START write with BUSY=0 -> LOAD (NUM_LEDS=0 -> LATCH directly); DONE is cleared.
  - LOAD: fetch RAM word for current LED into a 24-bit shift register, bit index 23 -> HIGH.
  - HIGH: led_o = 1 for T1H (bit=1) or T0H (bit=0) cycles -> LOW.
  - LOW: led_o = 0 for the remaining T_PERIOD minus high-time cycles; then next bit, or next LED (LOAD), or LATCH after the last bit of LED NUM_LEDS-1.
  - LATCH: led_o = 0 for LATCH cycles; then DONE=1 -> IDLE.
- Bits go out MSB first, LED 0 first. Total frame = NUM_LEDS*24*T_PERIOD + LATCH cycles (± FSM overhead, see Timing).
- START while BUSY is ignored. RAM/TIMING writes while BUSY are accepted; words not yet loaded and timing of subsequent bits use the new values.
- Clamping: T_PERIOD < 2 is treated as 2; high time ≥ T_PERIOD gives high for T_PERIOD-1 cycles, low for 1 cycle; high time 0 is treated as 1.

## Timing
- Wishbone: ack asserted exactly one cycle after cyc&stb is sampled, for one cycle; no ack for a new access in the ack cycle (back-to-back accesses take 2 cycles each). Read data valid with ack. No wait states beyond this, no errors.
- The START write takes effect the cycle after ack; BUSY reads 1 from then on.
- LOAD costs one cycle per LED and is absorbed into the LOW phase of the previous bit (first LED: led_o rises 2 cycles after the START ack), so the bit period is exactly T_PERIOD cycles.
- DONE and irq_o rise in the cycle after the last LATCH cycle.
- Reset (any time, including mid-frame): led_o = 0, led_oeb = 0, wbs_ack_o = 0, wbs_dat_o = 0, irq_o = 0, FSM IDLE, all registers to their reset values; RAM contents are retained.

## Test plan
- Register reset/readback: after reset, read TIMING -> 0x001C0E32, LATCH -> 2000; write/read 0x00A5A5A5 to RAM[0..63] and 0x5A to NUM_LEDS -> identical readback, no mismatches.
- Byte select: write 0xFFFFFFFF to RAM[3] with sel=4'b0010 over 0 -> reads 0x0000FF00.
- One LED: RAM[0]=0x800001, NUM_LEDS=1, START -> led_o shows high 28 / low 22 for bit 23, 14/36 for bits 22..1, 28/22 for bit 0, then 2000 low cycles; DONE=1, BUSY=0.
- Three LEDs, IRQ_EN=1 -> exactly 72 rising edges on led_o, irq_o asserts after the latch period, writing CTRL=0x2 clears DONE and irq_o.
- NUM_LEDS=0 plus START -> no pulses, DONE after LATCH cycles; START while BUSY -> frame length unchanged.
- wb_rst_i asserted mid-frame -> led_o=0 next cycle, BUSY=0, TIMING back to reset value, RAM retained.
